// File: rtl/pir_event_conditioner_pkg.sv
// Shared types and default timing constants for the PIR event conditioner.
// Defaults assume a 100 MHz clock.
package pir_pkg;

    typedef enum logic [1:0] {
        WARMUP   = 2'd0,
        IDLE     = 2'd1,
        ACTIVE   = 2'd2,
        COOLDOWN = 2'd3
    } pir_state_t;

    localparam longint unsigned DEF_WARMUP_CYCLES   = 64'd3_000_000_000;
    localparam longint unsigned DEF_FILTER_CYCLES   = 64'd1_000;
    localparam longint unsigned DEF_HOLD_CYCLES     = 64'd200_000_000;
    localparam longint unsigned DEF_COOLDOWN_CYCLES = 64'd100_000_000;
    localparam int              DEF_CNT_WIDTH       = 16;

    // Bits needed for a counter that must be able to hold maxCount itself.
    function automatic int timerWidth(input longint unsigned maxCount);
        return $clog2(maxCount + 64'd1);
    endfunction

endpackage

// File: rtl/pir_event_conditioner_glitch_filter.sv
// Two-flop synchroniser followed by a stability counter that only lets the
// PIR level change once the synchronised input has differed for FILTER_CYCLES.
module pir_glitch_filter
    import pir_pkg::*;
#(
    parameter longint unsigned FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic aclk,
    input  logic areset,
    input  logic pir_in,
    output logic filtered_pir
);

    localparam int              FW          = timerWidth(FILTER_CYCLES);
    localparam logic [FW-1:0]   FILTER_LAST = FW'(FILTER_CYCLES - 64'd1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filtered;
    logic [FW-1:0] r_count;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pir_in;
            r_sync2 <= r_sync1;
        end
    end

    // Any return to agreement restarts the count, so short glitches never toggle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_filtered <= 1'b0;
            r_count    <= '0;
        end else if (r_sync2 == r_filtered) begin
            r_count <= '0;
        end else if (r_count == FILTER_LAST) begin
            r_filtered <= ~r_filtered;
            r_count    <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign filtered_pir = r_filtered;

endmodule

// File: rtl/pir_event_conditioner.sv
// Turns the raw PIR pin into motion events: warm-up mask, hold stretch,
// cooldown lockout and a saturating event counter for software.
module pir_event_conditioner
    import pir_pkg::*;
#(
    parameter longint unsigned WARMUP_CYCLES   = DEF_WARMUP_CYCLES,
    parameter longint unsigned FILTER_CYCLES   = DEF_FILTER_CYCLES,
    parameter longint unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter longint unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int              CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 pir_in,
    input  logic                 enable,
    input  logic                 clear_count,
    output logic                 motion_active,
    output logic                 motion_pulse,
    output logic                 warming_up,
    output logic                 filtered_pir,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] event_count
);

    // One timer is shared by all states, so it is sized for the largest count.
    localparam longint unsigned TIMER_MAX_WH =
        (WARMUP_CYCLES > HOLD_CYCLES) ? WARMUP_CYCLES : HOLD_CYCLES;
    localparam longint unsigned TIMER_MAX =
        (TIMER_MAX_WH > COOLDOWN_CYCLES) ? TIMER_MAX_WH : COOLDOWN_CYCLES;
    localparam int            TW            = timerWidth(TIMER_MAX);
    localparam logic [TW-1:0] WARMUP_LAST   = TW'(WARMUP_CYCLES - 64'd1);
    localparam logic [TW-1:0] HOLD_LOAD     = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] COOLDOWN_LAST = TW'(COOLDOWN_CYCLES - 64'd1);
    localparam logic [TW-1:0] TIMER_ONE     = TW'(1);

    pir_state_t           r_state;
    pir_state_t           w_stateNext;
    logic [TW-1:0]        r_timer;
    logic [TW-1:0]        w_timerNext;
    logic                 r_pulse;
    logic                 w_accept;
    logic [CNT_WIDTH-1:0] r_eventCount;
    logic [CNT_WIDTH-1:0] w_eventCountNext;
    logic                 w_filtered;

    pir_glitch_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .aclk        (aclk),
        .areset      (areset),
        .pir_in      (pir_in),
        .filtered_pir(w_filtered)
    );

    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        w_accept    = 1'b0;
        case (r_state)
            WARMUP: begin
                if (r_timer == WARMUP_LAST) begin
                    w_stateNext = IDLE;
                    w_timerNext = '0;
                end else begin
                    w_timerNext = r_timer + 1'b1;
                end
            end
            IDLE: begin
                if (w_filtered && enable) begin
                    w_stateNext = ACTIVE;
                    w_timerNext = HOLD_LOAD;
                    w_accept    = 1'b1;
                end
            end
            ACTIVE: begin
                if (!enable) begin
                    w_stateNext = IDLE;
                    w_timerNext = '0;
                end else if (w_filtered) begin
                    w_timerNext = HOLD_LOAD;
                end else if (r_timer == TIMER_ONE) begin
                    w_stateNext = COOLDOWN;
                    w_timerNext = '0;
                end else begin
                    w_timerNext = r_timer - 1'b1;
                end
            end
            COOLDOWN: begin
                if (!enable || (r_timer == COOLDOWN_LAST)) begin
                    w_stateNext = IDLE;
                    w_timerNext = '0;
                end else begin
                    w_timerNext = r_timer + 1'b1;
                end
            end
            default: begin
                w_stateNext = WARMUP;
                w_timerNext = '0;
            end
        endcase
    end

    // A clear coinciding with a new event still counts that event.
    always_comb begin
        w_eventCountNext = r_eventCount;
        if (w_accept) begin
            if (clear_count) begin
                w_eventCountNext = CNT_WIDTH'(1);
            end else if (r_eventCount != '1) begin
                w_eventCountNext = r_eventCount + 1'b1;
            end
        end else if (clear_count) begin
            w_eventCountNext = '0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= WARMUP;
            r_timer      <= '0;
            r_pulse      <= 1'b0;
            r_eventCount <= '0;
        end else begin
            r_state      <= w_stateNext;
            r_timer      <= w_timerNext;
            r_pulse      <= w_accept;
            r_eventCount <= w_eventCountNext;
        end
    end

    assign motion_active = (r_state == ACTIVE);
    assign warming_up    = (r_state == WARMUP);
    assign motion_pulse  = r_pulse;
    assign state_o       = r_state;
    assign event_count   = r_eventCount;
    assign filtered_pir  = w_filtered;

endmodule

// File: tb/tb_pir_event_conditioner.sv
// Scoreboard bench: stimulus queues the expected cycle and count of each
// motion_pulse, a negedge monitor pops and compares whenever a pulse appears.
module tb_pir_event_conditioner;

    localparam int CW = 4;

    typedef struct {
        int            cycle;
        logic [CW-1:0] count;
    } pulseExp_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic          pirIn;
    logic          enable;
    logic          clearCount;
    logic          motionActive;
    logic          motionPulse;
    logic          warmingUp;
    logic          filteredPir;
    logic [1:0]    stateO;
    logic [CW-1:0] eventCount;

    pulseExp_t     expQueue[$];
    pulseExp_t     monExp;
    logic [CW-1:0] expCount = '0;
    int            cyc = 0;
    int            checkCount = 0;
    int            passCount = 0;

    pir_event_conditioner #(
        .WARMUP_CYCLES  (64'd16),
        .FILTER_CYCLES  (64'd4),
        .HOLD_CYCLES    (64'd10),
        .COOLDOWN_CYCLES(64'd8),
        .CNT_WIDTH      (CW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .pir_in       (pirIn),
        .enable       (enable),
        .clear_count  (clearCount),
        .motion_active(motionActive),
        .motion_pulse (motionPulse),
        .warming_up   (warmingUp),
        .filtered_pir (filteredPir),
        .state_o      (stateO),
        .event_count  (eventCount)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic tickTo(input int target);
        while (cyc < target) @(negedge aclk);
    endtask

    // Reference count model: saturates at all-ones.
    task automatic expectPulse(input int atCycle);
        if (expCount != {CW{1'b1}}) expCount = expCount + 1'b1;
        expQueue.push_back('{atCycle, expCount});
    endtask

    always @(negedge aclk) begin
        if (motionPulse) begin
            if (expQueue.size() == 0) begin
                checkOutput("unexpected_pulse", 1, 0);
            end else begin
                monExp = expQueue.pop_front();
                checkOutput("pulse_cycle", cyc, monExp.cycle);
                checkOutput("pulse_count", eventCount, monExp.count);
                checkOutput("active_with_pulse", motionActive, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r, a, n, m, q, t, u;
        areset = 1'b1;
        pirIn = 1'b1;
        enable = 1'b1;
        clearCount = 1'b0;

        // Reset state, then warm-up masking a sensor that is high from the start
        @(negedge aclk);
        checkOutput("rst_warming", warmingUp, 1);
        checkOutput("rst_state", stateO, 0);
        checkOutput("rst_active", motionActive, 0);
        checkOutput("rst_pulse", motionPulse, 0);
        checkOutput("rst_filtered", filteredPir, 0);
        checkOutput("rst_count", eventCount, 0);
        areset = 1'b0;
        r = cyc;
        expectPulse(r + 17);
        tickTo(r + 15);
        checkOutput("warm_last_cycle", warmingUp, 1);
        tickTo(r + 16);
        checkOutput("warm_done", warmingUp, 0);
        checkOutput("warm_to_idle", stateO, 1);
        checkOutput("warm_filtered", filteredPir, 1);
        tickTo(r + 17);
        pirIn = 1'b0;
        tickTo(r + 41);
        checkOutput("t1_back_idle", stateO, 1);

        // Three-cycle glitch must not reach the filtered level
        a = cyc;
        pirIn = 1'b1;
        tickTo(a + 3);
        pirIn = 1'b0;
        tickTo(a + 5);
        checkOutput("glitch_filt_a", filteredPir, 0);
        tickTo(a + 10);
        checkOutput("glitch_filt_b", filteredPir, 0);
        checkOutput("glitch_count", eventCount, 1);
        checkOutput("glitch_state", stateO, 1);

        clearCount = 1'b1;
        tickTo(cyc + 1);
        clearCount = 1'b0;
        expCount = '0;
        checkOutput("clear_count", eventCount, 0);

        // Single event: latency, hold window, cooldown
        n = cyc;
        pirIn = 1'b1;
        expectPulse(n + 7);
        tickTo(n + 5);
        checkOutput("t3_filt_before", filteredPir, 0);
        tickTo(n + 6);
        checkOutput("t3_filt_rise", filteredPir, 1);
        tickTo(n + 7);
        checkOutput("t3_active_rise", motionActive, 1);
        checkOutput("t3_state_active", stateO, 2);
        tickTo(n + 20);
        pirIn = 1'b0;
        tickTo(n + 25);
        checkOutput("t3_filt_still", filteredPir, 1);
        tickTo(n + 26);
        checkOutput("t3_filt_fall", filteredPir, 0);
        tickTo(n + 35);
        checkOutput("t3_hold_last", motionActive, 1);
        tickTo(n + 36);
        checkOutput("t3_hold_end", motionActive, 0);
        checkOutput("t3_cooldown", stateO, 3);
        tickTo(n + 43);
        checkOutput("t3_cool_last", stateO, 3);
        tickTo(n + 44);
        checkOutput("t3_cool_end", stateO, 1);
        checkOutput("t3_count", eventCount, 1);

        // Re-pulse during cooldown is ignored
        m = cyc;
        pirIn = 1'b1;
        expectPulse(m + 7);
        tickTo(m + 7);
        pirIn = 1'b0;
        tickTo(m + 20);
        pirIn = 1'b1;
        tickTo(m + 23);
        checkOutput("t4a_cooldown", stateO, 3);
        tickTo(m + 24);
        pirIn = 1'b0;
        tickTo(m + 27);
        checkOutput("t4a_filt_high", filteredPir, 1);
        checkOutput("t4a_still_cool", stateO, 3);
        tickTo(m + 31);
        checkOutput("t4a_idle", stateO, 1);
        checkOutput("t4a_filt_low", filteredPir, 0);
        tickTo(m + 36);
        checkOutput("t4a_count", eventCount, 2);

        // Motion still present when cooldown ends starts a new event
        q = cyc;
        pirIn = 1'b1;
        expectPulse(q + 7);
        tickTo(q + 7);
        pirIn = 1'b0;
        tickTo(q + 24);
        pirIn = 1'b1;
        checkOutput("t4b_cooldown", stateO, 3);
        expectPulse(q + 32);
        tickTo(q + 31);
        checkOutput("t4b_idle", stateO, 1);
        checkOutput("t4b_filt", filteredPir, 1);
        tickTo(q + 32);
        pirIn = 1'b0;
        checkOutput("t4b_retrigger", stateO, 2);
        tickTo(q + 56);
        checkOutput("t4b_back_idle", stateO, 1);

        // Drive the counter into saturation
        for (int i = 0; i < 13; i++) begin
            t = cyc;
            pirIn = 1'b1;
            expectPulse(t + 7);
            tickTo(t + 7);
            pirIn = 1'b0;
            tickTo(t + 31);
        end
        checkOutput("sat_count", eventCount, 15);
        checkOutput("sat_state", stateO, 1);

        // Clear on the same cycle as an accepted event
        t = cyc;
        pirIn = 1'b1;
        expCount = CW'(1);
        expQueue.push_back('{t + 7, expCount});
        tickTo(t + 6);
        clearCount = 1'b1;
        tickTo(t + 7);
        clearCount = 1'b0;
        pirIn = 1'b0;
        tickTo(t + 31);
        checkOutput("clr_evt_count", eventCount, 1);

        // Disarm mid-event, re-arm while motion persists, then reset mid-event
        t = cyc;
        pirIn = 1'b1;
        expectPulse(t + 7);
        tickTo(t + 9);
        checkOutput("t6_active", stateO, 2);
        enable = 1'b0;
        tickTo(t + 10);
        checkOutput("t6_disarm_active", motionActive, 0);
        checkOutput("t6_disarm_state", stateO, 1);
        enable = 1'b1;
        expectPulse(t + 11);
        tickTo(t + 11);
        checkOutput("t6_rearm_state", stateO, 2);
        tickTo(t + 13);
        areset = 1'b1;
        pirIn = 1'b0;
        #1;
        expCount = '0;
        checkOutput("t6_rst_state", stateO, 0);
        checkOutput("t6_rst_warming", warmingUp, 1);
        checkOutput("t6_rst_active", motionActive, 0);
        checkOutput("t6_rst_pulse", motionPulse, 0);
        checkOutput("t6_rst_filtered", filteredPir, 0);
        checkOutput("t6_rst_count", eventCount, 0);
        @(negedge aclk);
        areset = 1'b0;
        u = cyc;
        tickTo(u + 15);
        checkOutput("t6_rewarm_last", warmingUp, 1);
        tickTo(u + 16);
        checkOutput("t6_rewarm_done", warmingUp, 0);
        checkOutput("t6_rewarm_idle", stateO, 1);
        tickTo(u + 20);
        checkOutput("scoreboard_drained", expQueue.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
